// File: rtl/qk_pkg.sv
// Shared FSM state encoding and bus widths for the QK score engine.
package qk_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Q = 3'd1,
    DOT_K  = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } qk_state_e;

endpackage

// File: rtl/qk_mac.sv
// 32-bit wrap-around multiply-accumulate register; clear has priority over enable.
module qk_mac
  import qk_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + a_i * b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/qk_score_engine.sv
// Computes S = Q * K^T from the result SRAM into the scratchpad, one score per write.
// Optional build macro QK_SCORE_SCALE_EN: written scores are shifted right by SCALE_SHIFT.
module qk_score_engine
  import qk_pkg::*;
#(
  parameter int unsigned MAX_COLS    = 16,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] cfg_rows,
  input  logic [ADDR_W-1:0] cfg_cols,
  input  logic [ADDR_W-1:0] cfg_q_base,
  input  logic [ADDR_W-1:0] cfg_k_base,
  input  logic [ADDR_W-1:0] cfg_s_base,
  output logic [ADDR_W-1:0] res_rd_addr,
  input  logic [DATA_W-1:0] res_rd_data,
  output logic              spad_we,
  output logic [ADDR_W-1:0] spad_wr_addr,
  output logic [DATA_W-1:0] spad_wr_data,
  output logic              cfg_err
);

  localparam int unsigned IDX_W = $clog2(MAX_COLS);

`ifdef QK_SCORE_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif
  localparam int unsigned SHIFT_AMT = SCALE_EN ? SCALE_SHIFT : 0;

  function automatic logic [DATA_W-1:0] scale_score(input logic [DATA_W-1:0] v);
    return v >> SHIFT_AMT;
  endfunction

  qk_state_e         state_q, state_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] rows_q, rows_d;
  logic [ADDR_W-1:0] cols_q, cols_d;
  logic [ADDR_W-1:0] k_base_q, k_base_d;
  logic [ADDR_W-1:0] q_ptr_q, q_ptr_d;
  logic [ADDR_W-1:0] k_ptr_q, k_ptr_d;
  logic [ADDR_W-1:0] s_ptr_q, s_ptr_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

  logic [DATA_W-1:0] qbuf_q [MAX_COLS];

  logic              accept;
  logic              last_k;
  logic              rd_issue;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_acc;

  assign accept   = start_valid && ready_q && (state_q == IDLE);
  assign last_k   = (k_q == cols_q);
  assign rd_issue = ((state_q == LOAD_Q) || (state_q == DOT_K)) && !last_k;

  // Reads return one cycle later; rd_pend/rd_idx tag the word arriving this cycle.
  always_comb begin
    state_d   = state_q;
    ready_d   = (state_q == IDLE) && !accept;
    err_d     = err_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    k_base_d  = k_base_q;
    q_ptr_d   = q_ptr_q;
    k_ptr_d   = k_ptr_q;
    s_ptr_d   = s_ptr_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    rd_pend_d = rd_issue;
    rd_idx_d  = k_q[IDX_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rows_d   = cfg_rows;
          cols_d   = cfg_cols;
          k_base_d = cfg_k_base;
          q_ptr_d  = cfg_q_base;
          k_ptr_d  = cfg_k_base;
          s_ptr_d  = cfg_s_base;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          err_d    = (cfg_cols > ADDR_W'(MAX_COLS));
          if ((cfg_rows == '0) || (cfg_cols == '0) || (cfg_cols > ADDR_W'(MAX_COLS))) begin
            state_d = DONE;
          end else begin
            state_d = LOAD_Q;
          end
        end
      end
      LOAD_Q: begin
        if (last_k) begin
          k_d     = '0;
          state_d = DOT_K;
        end else begin
          k_d = k_q + 16'd1;
        end
      end
      DOT_K: begin
        if (last_k) begin
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d = k_q + 16'd1;
        end
      end
      WRITE: begin
        s_ptr_d = s_ptr_q + 16'd1;
        if (j_q != rows_q - 16'd1) begin
          j_d     = j_q + 16'd1;
          k_ptr_d = k_ptr_q + cols_q;
          state_d = DOT_K;
        end else if (i_q != rows_q - 16'd1) begin
          i_d     = i_q + 16'd1;
          j_d     = '0;
          q_ptr_d = q_ptr_q + cols_q;
          k_ptr_d = k_base_q;
          state_d = LOAD_Q;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      k_base_q  <= '0;
      q_ptr_q   <= '0;
      k_ptr_q   <= '0;
      s_ptr_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      k_base_q  <= k_base_d;
      q_ptr_q   <= q_ptr_d;
      k_ptr_q   <= k_ptr_d;
      s_ptr_q   <= s_ptr_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOAD_Q) && rd_pend_q) begin
      qbuf_q[rd_idx_q] <= res_rd_data;
    end
  end

  // Accumulator is cleared in the first DOT_K cycle, before any K word returns.
  assign mac_clr = (state_q == DOT_K) && (k_q == '0);
  assign mac_en  = (state_q == DOT_K) && rd_pend_q;

  qk_mac u_mac (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (res_rd_data),
    .b_i    (qbuf_q[rd_idx_q]),
    .acc_o  (mac_acc)
  );

  assign start_ready  = ready_q;
  assign cfg_err      = err_q;
  assign res_rd_addr  = rd_issue ? (((state_q == LOAD_Q) ? q_ptr_q : k_ptr_q) + k_q) : '0;
  assign spad_we      = (state_q == WRITE);
  assign spad_wr_addr = s_ptr_q;
  assign spad_wr_data = scale_score(mac_acc);

endmodule

// File: tb/tb_qk_score_engine.sv
// Scoreboard bench for qk_score_engine: randomized and directed jobs vs. a loop-level model.
module tb_qk_score_engine;

  localparam int MAX_COLS    = 16;
  localparam int SCALE_SHIFT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] cfg_rows, cfg_cols, cfg_q_base, cfg_k_base, cfg_s_base;
  logic [15:0] res_rd_addr;
  logic [31:0] res_rd_data;
  logic        spad_we;
  logic [15:0] spad_wr_addr;
  logic [31:0] spad_wr_data;
  logic        cfg_err;

  logic [31:0] mem [65536];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  qk_score_engine #(.MAX_COLS(MAX_COLS), .SCALE_SHIFT(SCALE_SHIFT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .cfg_rows     (cfg_rows),
    .cfg_cols     (cfg_cols),
    .cfg_q_base   (cfg_q_base),
    .cfg_k_base   (cfg_k_base),
    .cfg_s_base   (cfg_s_base),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .spad_we      (spad_we),
    .spad_wr_addr (spad_wr_addr),
    .spad_wr_data (spad_wr_data),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  // Result SRAM with one-cycle read latency.
  always @(posedge clk) res_rd_data <= mem[res_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every scratchpad write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (spad_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_write: got write addr 0x%04h data 0x%08h, required no write",
                 spad_wr_addr, spad_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, spad_wr_addr}, {16'd0, e.addr});
        check("wr_data", spad_wr_data, e.data);
      end
    end
  end

  function automatic logic [31:0] scale(input logic [31:0] v);
`ifdef QK_SCORE_SCALE_EN
    return v >> SCALE_SHIFT;
`else
    return v;
`endif
  endfunction

  function automatic int exp_latency(input int n, input int d);
    if (n == 0 || d == 0 || d > MAX_COLS) return 2;
    return n * (d + 1) + n * n * (d + 2) + 2;
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [31:0] v);
    wr_t e;
    e.addr = a;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic fill(input logic [15:0] base, input int count);
    for (int c = 0; c < count; c++) begin
      logic [15:0] a;
      a = 16'(base + c);
      mem[a] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
    end
  endtask

  // Reference: S[i][j] = sum_k Q[i][k] * K[j][k] mod 2^32, written row-major.
  task automatic push_model(input int n, input int d, input logic [15:0] qb,
                            input logic [15:0] kb, input logic [15:0] sb);
    if (n == 0 || d == 0 || d > MAX_COLS) return;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        logic [31:0] acc;
        acc = 32'd0;
        for (int k = 0; k < d; k++) begin
          logic [15:0] qa, ka;
          qa  = 16'(qb + i * d + k);
          ka  = 16'(kb + j * d + k);
          acc = acc + mem[qa] * mem[ka];
        end
        push_exp(16'(sb + i * n + j), scale(acc));
      end
    end
  endtask

  task automatic set_cfg(input int n, input int d, input logic [15:0] qb,
                         input logic [15:0] kb, input logic [15:0] sb);
    cfg_rows   = 16'(n);
    cfg_cols   = 16'(d);
    cfg_q_base = qb;
    cfg_k_base = kb;
    cfg_s_base = sb;
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue_start(input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (start_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      if (!hold) start_valid = 1'b0;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL start_timeout: got start_ready=0 for 100 cycles, required 1");
      start_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (start_ready !== 1'b1 && cyc < 3000);
  endtask

  task automatic run_job(input string tag, input int n, input int d);
    int lat;
    issue_start(1'b0);
    wait_ready(lat);
    check({tag, "_latency"}, lat, exp_latency(n, d));
    check({tag, "_cfg_err"}, {31'd0, cfg_err}, (d > MAX_COLS) ? 32'd1 : 32'd0);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s30 [4];
    logic [31:0] s31;
    int          lat;
    int          n, d;
    logic [15:0] qb, kb, sb;

`ifdef QK_SCORE_SCALE_EN
    s30 = '{32'd4, 32'd5, 32'd9, 32'd13};
    s31 = 32'h0000_0004;
`else
    s30 = '{32'd17, 32'd23, 32'd39, 32'd53};
    s31 = 32'h0000_0010;
`endif

    reset_n     = 1'b0;
    start_valid = 1'b0;
    set_cfg(0, 0, 16'd0, 16'd0, 16'd0);
    #12;
    check("rst_start_ready", {31'd0, start_ready}, 32'd0);
    check("rst_spad_we", {31'd0, spad_we}, 32'd0);
    check("rst_rd_addr", {16'd0, res_rd_addr}, 32'd0);
    check("rst_wr_addr", {16'd0, spad_wr_addr}, 32'd0);
    check("rst_wr_data", spad_wr_data, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", {31'd0, start_ready}, 32'd1);

    // 2x2 directed case.
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 8;
    set_cfg(2, 2, 16'd0, 16'd4, 16'd0);
    for (int i = 0; i < 4; i++) push_exp(16'(i), s30[i]);
    run_job("dir2x2", 2, 2);

    // All-ones, full width row: wraps modulo 2^32.
    for (int c = 0; c < 16; c++) begin
      mem[100 + c] = 32'hFFFF_FFFF;
      mem[200 + c] = 32'hFFFF_FFFF;
    end
    set_cfg(1, 16, 16'd100, 16'd200, 16'd500);
    push_exp(16'd500, s31);
    run_job("allones", 1, 16);

    // Too many columns: error, no writes, sticky flag.
    set_cfg(2, 17, 16'd0, 16'd4, 16'd0);
    run_job("d17", 2, 17);
    repeat (3) @(posedge clk);
    #1;
    check("d17_err_sticky", {31'd0, cfg_err}, 32'd1);

    set_cfg(0, 4, 16'd0, 16'd4, 16'd0);
    run_job("n0", 0, 4);
    set_cfg(3, 0, 16'd0, 16'd4, 16'd0);
    run_job("d0", 3, 0);

    // Reset in the middle of the first dot product, then restart.
    set_cfg(2, 2, 16'd0, 16'd4, 16'd0);
    issue_start(1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_spad_we", {31'd0, spad_we}, 32'd0);
    check("midrst_ready", {31'd0, start_ready}, 32'd0);
    check("midrst_rd_addr", {16'd0, res_rd_addr}, 32'd0);
    check("midrst_wr_data", spad_wr_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(16'(i), s30[i]);
    run_job("midrst_redo", 2, 2);

    // start_valid held high: exactly one job per ready window.
    fill(16'd1000, 6);
    fill(16'd2000, 6);
    fill(16'd3000, 2);
    fill(16'd3100, 2);
    set_cfg(2, 3, 16'd1000, 16'd2000, 16'd300);
    push_model(2, 3, 16'd1000, 16'd2000, 16'd300);
    issue_start(1'b1);
    set_cfg(1, 2, 16'd3000, 16'd3100, 16'd400);
    push_model(1, 2, 16'd3000, 16'd3100, 16'd400);
    wait_ready(lat);
    check("hold_a_latency", lat, exp_latency(2, 3));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    check("hold_b_busy", {31'd0, start_ready}, 32'd0);
    wait_ready(lat);
    check("hold_b_latency", lat, exp_latency(1, 2));
    repeat (5) @(posedge clk);
    #1;
    check("hold_drain", exp_q.size(), 0);

    // Randomized jobs, the last one wrapping the address space.
    for (int t = 0; t < 7; t++) begin
      n  = $urandom_range(1, 4);
      d  = $urandom_range(1, MAX_COLS);
      qb = 16'($urandom);
      kb = 16'($urandom);
      sb = 16'($urandom);
      if (t == 6) begin
        n  = 2;
        d  = 8;
        qb = 16'hFFF8;
        sb = 16'hFFFE;
      end
      fill(qb, n * d);
      fill(kb, n * d);
      set_cfg(n, d, qb, kb, sb);
      push_model(n, d, qb, kb, sb);
      run_job($sformatf("rand%0d", t), n, d);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qk_score_engine.md
QK_SCORE_ENGINE -- requirements
Module: qk_score_engine

Interface
REQ-001 SHALL have parameter MAX_COLS, default 16, meaning maximum row length (inner dimension) of Q/K, power of two.
REQ-002 SHALL have parameter SCALE_SHIFT, default 2, meaning right-shift applied to each score when scaling is compiled in.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `reset_n` (in, 1, asynchronous active-low reset), one clock domain; the reset is asynchronous and active-low.
REQ-004 SHALL have ports `start_valid` (in, 1, start request) and `start_ready` (out, 1, idle/accepting, registered).
REQ-005 SHALL have ports `cfg_rows` and `cfg_cols` (in, 16 each), meaning sequence length N and inner dimension D.
REQ-006 SHALL have ports `cfg_q_base`, `cfg_k_base` and `cfg_s_base` (in, 16 each), meaning word base addresses of Q and K (result SRAM) and S (scratchpad).
REQ-007 SHALL have ports `res_rd_addr` (out, 16) and `res_rd_data` (in, 32), forming the result SRAM read port.
REQ-008 SHALL have ports `spad_we` (out, 1), `spad_wr_addr` (out, 16) and `spad_wr_data` (out, 32), forming the scratchpad write port.
REQ-009 SHALL have port `cfg_err` (out, 1), meaning the last request was rejected; it is sticky until the next accepted start.

Function
REQ-010 SHALL compute S[i][j] = sum over k<D of Q[i][k]*K[j][k], for i,j < N, where Q[i][k] is at cfg_q_base+i*D+k and K[j][k] is at cfg_k_base+j*D+k.
REQ-011 SHALL write S[i][j] to cfg_s_base+i*N+j in row-major order, one write per score, with ascending addresses.
REQ-012 SHALL treat SRAM read latency as exactly 1 cycle: data for an address driven in cycle t is sampled in cycle t+1.
REQ-013 SHALL accept a start when start_valid=1 and start_ready=1 in the same cycle; cfg_* SHALL be latched in that cycle, and start_ready SHALL be 0 from the next cycle until completion.
REQ-014 SHALL use FSM states IDLE, LOAD_Q, DOT_K, WRITE and DONE.
REQ-015 IDLE SHALL go to LOAD_Q on accept, or to DONE if N=0, D=0 or D>MAX_COLS.
REQ-016 LOAD_Q SHALL issue D consecutive reads of Q row i into a local MAX_COLS x 32 buffer, then go to DOT_K.
REQ-017 DOT_K SHALL issue D consecutive reads of K row j, with one multiply-accumulate per returned word against buffer[k], then go to WRITE.
REQ-018 WRITE SHALL pulse spad_we for exactly 1 cycle, then: go to DOT_K with j+1 if j<N-1; else go to LOAD_Q with i+1, j=0, if i<N-1; else go to DONE.
REQ-019 DONE SHALL last 1 cycle, return to IDLE, and have start_ready=1 from the following cycle.
REQ-020 SHALL take exactly N*(D+1) + N*N*(D+2) + 2 cycles from accept to start_ready re-assertion for legal N, D.
REQ-021 SHALL compute products and accumulation modulo 2^32 (unsigned, wrap-around) and clear the accumulator at the start of every DOT_K.
REQ-022 SHALL keep spad_we=0 outside WRITE, and spad_wr_data/spad_wr_addr SHALL be stable during the WRITE cycle.
REQ-023 SHALL set cfg_err=1 with zero writes for D>MAX_COLS; N=0 or D=0 SHALL complete with zero writes and cfg_err=0.
REQ-024 SHALL ignore start_valid while busy, and SHALL compute addresses modulo 2^16 (wrap-around).

Reset
REQ-025 SHALL, on reset_n=0 at any time including mid-operation, immediately force: FSM=IDLE, start_ready=0, spad_we=0, spad_wr_addr=0, spad_wr_data=0, res_rd_addr=0, cfg_err=0, and clear counters and accumulator.
REQ-026 SHALL assert start_ready on the first clock edge after reset_n deasserts; the Q buffer contents need not be reset.

Configuration
REQ-027 SHALL use macro QK_SCORE_SCALE_EN: when defined, the written score is the accumulated value logically shifted right by SCALE_SHIFT; when undefined, the raw 32-bit sum is written and SCALE_SHIFT is unused; latency is identical either way.

Structure
REQ-028 SHALL place the FSM state enum (3-bit) and the address-width/data-width constants in a shared package, qk_pkg.
REQ-029 SHALL use one sub-module, qk_mac, holding the 32-bit multiply-accumulate register with clear/enable.

Verification
REQ-030 SHALL cover: N=2, D=2, Q=[[1,2],[3,4]], K=[[5,6],[7,8]], bases 0/4/0 -> S=[17,23,39,53] at scratchpad 0..3, done in 24 cycles.
REQ-031 SHALL cover: N=1, D=16 with all elements 0xFFFFFFFF -> single write of 0x00000010 (mod 2^32).
REQ-032 SHALL cover: D=17 (MAX_COLS=16) -> no spad_we, cfg_err=1, start_ready back after 2 cycles.
REQ-033 SHALL cover: reset_n pulsed low mid-DOT_K in the N=2, D=2 case -> spad_we=0 immediately, then a restart yields correct S.
REQ-034 SHALL cover: start_valid held high throughout an operation -> exactly one operation per start_ready window, with no extra writes.
REQ-035 SHALL cover: QK_SCORE_SCALE_EN defined, SCALE_SHIFT=2, in the REQ-030 case -> S=[4,5,9,13].
